// File: rtl/st_c2h_gen_if.sv
// st_c2h_gen_if: AXI4-Stream C2H bus with queue/length/mty sideband.
// The master drives beats and sideband; the slave returns tready.
`timescale 1ns/1ps
interface st_c2h_gen_if #(
  parameter int BIT_WIDTH = 64,
  parameter int QID_WIDTH = 11
);
  logic                 c2h_tvalid;
  logic                 c2h_tready;
  logic [BIT_WIDTH-1:0] c2h_tdata;
  logic                 c2h_tlast;
  logic [5:0]           c2h_mty;
  logic [QID_WIDTH-1:0] c2h_qid_out;
  logic [15:0]          c2h_len;

  modport master (
    output c2h_tvalid, c2h_tdata, c2h_tlast, c2h_mty, c2h_qid_out, c2h_len,
    input  c2h_tready
  );

  modport slave (
    input  c2h_tvalid, c2h_tdata, c2h_tlast, c2h_mty, c2h_qid_out, c2h_len,
    output c2h_tready
  );
endinterface

// File: rtl/st_c2h_gen.sv
// st_c2h_gen: stream C2H traffic generator. Emits packets of an incrementing
// 16-bit word pattern with qid/len/mty sideband; a rising edge of control_run
// starts a job of c2h_num_pkt packets of c2h_txr_size bytes each.
// Optional macro ST_C2H_PKT_GAP_EN inserts one idle cycle between packets.
`timescale 1ns/1ps
module st_c2h_gen #(
  parameter int BIT_WIDTH = 64,
  parameter int QID_WIDTH = 11
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic                 control_run,
  input  logic [15:0]          c2h_txr_size,
  input  logic [31:0]          c2h_num_pkt,
  input  logic [QID_WIDTH-1:0] c2h_qid,
  st_c2h_gen_if.master         c2h,
  output logic                 c2h_busy,
  output logic                 c2h_done,
  output logic [31:0]          c2h_pkt_count
);

  localparam int BYTES  = BIT_WIDTH / 8;
  localparam int WORDS  = BIT_WIDTH / 16;
  localparam int BSHIFT = $clog2(BYTES);
  localparam int WSHIFT = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    SEND
`ifdef ST_C2H_PKT_GAP_EN
    , GAP
`endif
  } state_t;

  state_t               state, state_nxt;
  logic                 run_d1;
  logic [15:0]          size_r;
  logic [31:0]          num_r;
  logic [15:0]          beat;
  logic                 tvalid;
  logic [BIT_WIDTH-1:0] tdata;
  logic                 tlast;
  logic [5:0]           mty;
  logic [QID_WIDTH-1:0] qid_out;
  logic [15:0]          len;

  logic                 start, hs, job_end, present;
  logic                 valid_nxt, busy_nxt, done_nxt;
  logic [15:0]          beat_nxt, cur_size, last_idx;
  logic [16:0]          beats;
  logic [5:0]           mty_val;
  logic [31:0]          cnt_inc;

  // Pattern for one beat: word k carries (b*WORDS + k) mod 2^16.
  function automatic logic [BIT_WIDTH-1:0] pattern(input logic [15:0] b);
    logic [BIT_WIDTH-1:0] res;
    logic [15:0]          base;
    base = b << WSHIFT;
    res  = '0;
    for (int k = 0; k < WORDS; k++) res[16*k +: 16] = base + 16'(k);
    return res;
  endfunction

  assign c2h.c2h_tvalid  = tvalid;
  assign c2h.c2h_tdata   = tdata;
  assign c2h.c2h_tlast   = tlast;
  assign c2h.c2h_mty     = mty;
  assign c2h.c2h_qid_out = qid_out;
  assign c2h.c2h_len     = len;

  // In IDLE the geometry comes straight from the inputs so beat 0 can be
  // presented the cycle after the start edge; afterwards from the latched size.
  assign cur_size = (state == IDLE) ? c2h_txr_size : size_r;
  assign beats    = ({1'b0, cur_size} + 17'(BYTES - 1)) >> BSHIFT;
  assign last_idx = 16'(beats - 17'd1);
  assign mty_val  = 6'((beats << BSHIFT) - {1'b0, cur_size});

  assign hs      = tvalid & c2h.c2h_tready;
  assign cnt_inc = c2h_pkt_count + 32'd1;
  assign start   = control_run & ~run_d1 & (state == IDLE) &
                   (c2h_txr_size != 16'd0) & (c2h_num_pkt != 32'd0);
  assign job_end = (cnt_inc == num_r) | ~control_run;

  // Next state plus the next values of valid/busy/done and which beat to load.
  always_comb begin
    state_nxt = state;
    present   = 1'b0;
    beat_nxt  = 16'd0;
    valid_nxt = tvalid;
    busy_nxt  = c2h_busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SEND;
          present   = 1'b1;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      SEND: begin
        if (hs) begin
          if (tlast) begin
            if (job_end) begin
              state_nxt = IDLE;
              valid_nxt = 1'b0;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
`ifdef ST_C2H_PKT_GAP_EN
              state_nxt = GAP;
              valid_nxt = 1'b0;
`else
              present   = 1'b1;
`endif
            end
          end else begin
            present  = 1'b1;
            beat_nxt = beat + 16'd1;
          end
        end
      end
`ifdef ST_C2H_PKT_GAP_EN
      GAP: begin
        state_nxt = SEND;
        present   = 1'b1;
        valid_nxt = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) state <= IDLE;
    else              state <= state_nxt;
  end

  // Job control: run edge detect, busy/done, packet counter.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      run_d1        <= 1'b0;
      c2h_busy      <= 1'b0;
      c2h_done      <= 1'b0;
      c2h_pkt_count <= 32'd0;
    end else begin
      run_d1   <= control_run;
      c2h_busy <= busy_nxt;
      c2h_done <= done_nxt;
      if (start)            c2h_pkt_count <= 32'd0;
      else if (hs && tlast) c2h_pkt_count <= cnt_inc;
    end
  end

  // Job parameters; only read after a start has loaded them.
  always_ff @(posedge axi_aclk) begin
    if (start) begin
      size_r <= c2h_txr_size;
      num_r  <= c2h_num_pkt;
    end
  end

  // Stream outputs: load a new beat when the FSM says so, otherwise hold.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      beat    <= 16'd0;
      tvalid  <= 1'b0;
      tdata   <= '0;
      tlast   <= 1'b0;
      mty     <= 6'd0;
      qid_out <= '0;
      len     <= 16'd0;
    end else begin
      tvalid <= valid_nxt;
      if (present) begin
        beat  <= beat_nxt;
        tdata <= pattern(beat_nxt);
        tlast <= (beat_nxt == last_idx);
        mty   <= (beat_nxt == last_idx) ? mty_val : 6'd0;
      end else if (!valid_nxt) begin
        tlast <= 1'b0;
        mty   <= 6'd0;
      end
      if (start) begin
        qid_out <= c2h_qid;
        len     <= c2h_txr_size;
      end
    end
  end

endmodule
